// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - rectangle rasteriser with clipping, outline mode and pixel backpressure
//
// Purpose:
//   Takes one rectangle command at a time and emits its pixels in row-major
//   order, one per cycle, to the VGA adapter. Pixels falling off-screen and
//   interior pixels in outline mode still take one scan cycle each, but they
//   are presented with plot=0.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake; cmd_* fields are latched on acceptance
//   cmd_x, cmd_y            rectangle origin
//   cmd_w, cmd_h            rectangle size (either may be 0)
//   cmd_color, cmd_outline  fill colour, border-only select
//   pix_x, pix_y, pix_color registered pixel position and colour
//   plot                    pixel write strobe
//   pix_ready               downstream accepts the presented pixel
//   busy                    high while rasterising
//   done                    one-cycle pulse when a command completes
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] cmd_w,
  input  logic [Y_W-1:0] cmd_h,
  input  logic [C_W-1:0] cmd_color,
  input  logic           cmd_outline,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [C_W-1:0] pix_color,
  output logic           plot,
  input  logic           pix_ready,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  // Screen limits at the widened arithmetic width, so a carry out of the
  // narrow coordinate also lands outside the screen.
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t         state_q, state_d;
  logic [X_W-1:0] x0_q, x0_d;
  logic [Y_W-1:0] y0_q, y0_d;
  logic [X_W-1:0] w_q, w_d;
  logic [Y_W-1:0] h_q, h_d;
  logic [C_W-1:0] color_q, color_d;
  logic           outline_q, outline_d;
  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic [X_W-1:0] pix_x_q, pix_x_d;
  logic [Y_W-1:0] pix_y_q, pix_y_d;
  logic [C_W-1:0] pix_color_q, pix_color_d;
  logic           plot_q, plot_d;

  logic           load_pix;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           on_border;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      outline_q   <= 1'b0;
      cx_q        <= '0;
      cy_q        <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      plot_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      outline_q   <= outline_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      plot_q      <= plot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    outline_d   = outline_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    plot_d      = plot_q;
    load_pix    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d      = cmd_x;
          y0_d      = cmd_y;
          w_d       = cmd_w;
          h_d       = cmd_h;
          color_d   = cmd_color;
          outline_d = cmd_outline;
          cx_d      = '0;
          cy_d      = '0;
          if (cmd_w == '0 || cmd_h == '0) begin
            state_d = DONE;
            plot_d  = 1'b0;
          end else begin
            state_d  = DRAW;
            load_pix = 1'b1;
          end
        end
      end
      DRAW: begin
        // A presented pixel that is not plotted never waits on pix_ready.
        if (!plot_q || pix_ready) begin
          if (cx_q == w_q - X_W'(1)) begin
            cx_d = '0;
            if (cy_q == h_q - Y_W'(1)) begin
              state_d = DONE;
              plot_d  = 1'b0;
            end else begin
              cy_d     = cy_q + Y_W'(1);
              load_pix = 1'b1;
            end
          end else begin
            cx_d     = cx_q + X_W'(1);
            load_pix = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pixel outputs are computed from the next offsets so they appear
    // registered, one cycle after acceptance or advance.
    sum_x     = {1'b0, x0_d} + {1'b0, cx_d};
    sum_y     = {1'b0, y0_d} + {1'b0, cy_d};
    on_border = (cx_d == '0) || (cx_d == w_d - X_W'(1)) ||
                (cy_d == '0) || (cy_d == h_d - Y_W'(1));
    if (load_pix) begin
      pix_x_d     = sum_x[X_W-1:0];
      pix_y_d     = sum_y[Y_W-1:0];
      pix_color_d = color_d;
      plot_d      = (sum_x < SCR_W) && (sum_y < SCR_H) && (!outline_d || on_border);
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign plot      = plot_q;
  assign busy      = (state_q == DRAW);
  assign done      = (state_q == DONE);
  assign cmd_ready = (state_q == IDLE);

endmodule
